// File: rtl/amp3_pkg.sv
// Shared definitions for the AMP3 I2S scheduler: FSM state encoding, channel codes and a slot helper.
package amp3_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_OFF    = 2'd0;
    localparam state_t ST_WARMUP = 2'd1;
    localparam state_t ST_RUN    = 2'd2;
    localparam state_t ST_DRAIN  = 2'd3;

    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    // True when frame position pos carries a sample bit (one BCLK after each LRCLK edge).
    function automatic logic is_data_bit(input int pos, input int slotbits, input int datasize);
        return ((pos >= 1) && (pos <= datasize)) ||
               ((pos >= slotbits + 1) && (pos <= slotbits + datasize));
    endfunction

endpackage

// File: rtl/amp3_i2s_scheduler_if.sv
// Stereo sample source handshake: the source presents a pair and holds it until ready strobes.
interface amp3_i2s_scheduler_if #(
    parameter int DATASIZE = 12
);
    logic                valid;
    logic [DATASIZE-1:0] data_l;
    logic [DATASIZE-1:0] data_r;
    logic                ready;

    modport master (output valid, data_l, data_r, input ready);
    modport slave  (input valid, data_l, data_r, output ready);
endinterface

// File: rtl/amp3_bclk_gen.sv
// BCLK divider: toggles every CLKDIV clk cycles while running, flags the cycle that ends in a 1->0 edge.
module amp3_bclk_gen #(
    parameter int CLKDIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_bclk,
    output logic o_fall
);
    localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKDIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_bclk;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_bclk <= 1'b0;
        end else if (!i_run) begin
            r_cnt  <= '0;
            r_bclk <= 1'b0;
        end else if (w_wrap) begin
            r_cnt  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_bclk = r_bclk;
    assign o_fall = i_run & r_bclk & w_wrap;
endmodule

// File: rtl/amp3_i2s_scheduler.sv
// AMP3 I2S frame scheduler: power sequencing FSM, frame position counter, per-frame sticky
// arbitration between two stereo sources, and the serialising frame buffer.
module amp3_i2s_scheduler
    import amp3_pkg::*;
#(
    parameter int DATASIZE      = 12,
    parameter int SLOTBITS      = 16,
    parameter int CLKDIV        = 16,
    parameter int WARMUP_FRAMES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_enable,
    amp3_i2s_scheduler_if.slave        i_src0,
    amp3_i2s_scheduler_if.slave        i_src1,
    output logic                       o_owner,
    output logic                       o_underrun,
    output logic                       o_busy,
    output logic                       o_bclk,
    output logic                       o_lrclk,
    output logic                       o_sdata,
    output logic                       o_nshut
);
    localparam int FRAMEBITS = 2 * SLOTBITS;
    localparam int PW        = $clog2(FRAMEBITS);
    localparam int WW        = (WARMUP_FRAMES > 0) ? $clog2(WARMUP_FRAMES + 1) : 1;
    localparam int BW        = 2 * DATASIZE;
    localparam logic [PW-1:0] POS_LAST = PW'(FRAMEBITS - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_pos;
    logic [PW-1:0]   w_pos_nxt;
    logic            r_started;
    logic [WW-1:0]   r_warm;
    logic [BW-1:0]   r_buf;
    logic [BW-1:0]   w_pair;
    logic            r_owner;
    logic            r_lrclk;
    logic            r_sdata;
    logic            w_run;
    logic            w_fall;
    logic            w_frame_start;
    logic            w_warm_done;
    logic            w_serve;
    logic            w_own_valid;
    logic            w_oth_valid;
    logic            w_grant;
    logic            w_win;

    amp3_bclk_gen #(.CLKDIV(CLKDIV)) u_bclk_gen (
        .clk    (clk),
        .rst    (rst),
        .i_run  (w_run),
        .o_bclk (o_bclk),
        .o_fall (w_fall)
    );

    assign w_run = (r_state != ST_OFF);

    // The first fall after OFF opens a frame even though r_pos already reads 0.
    assign w_pos_nxt     = (!r_started || (r_pos == POS_LAST)) ? '0 : r_pos + PW'(1);
    assign w_frame_start = w_fall && (w_pos_nxt == '0);
    assign w_warm_done   = (r_warm == WW'(WARMUP_FRAMES));
    assign w_serve       = w_frame_start && i_enable &&
                           ((r_state == ST_RUN) || ((r_state == ST_WARMUP) && w_warm_done));

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_own_valid = r_owner ? i_src1.valid : i_src0.valid;
        w_oth_valid = r_owner ? i_src0.valid : i_src1.valid;
        w_grant     = w_serve && (w_own_valid || w_oth_valid);
        w_win       = w_own_valid ? r_owner : ~r_owner;
        w_pair      = w_win ? {i_src1.data_l, i_src1.data_r} : {i_src0.data_l, i_src0.data_r};
    end

    assign i_src0.ready = w_grant && !w_win;
    assign i_src1.ready = w_grant && w_win;
    assign o_underrun   = w_serve && !w_grant;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OFF:    if (i_enable) w_state_nxt = ST_WARMUP;
            ST_WARMUP: begin
                if (!i_enable)                         w_state_nxt = ST_DRAIN;
                else if (w_frame_start && w_warm_done) w_state_nxt = ST_RUN;
            end
            ST_RUN:    if (!i_enable) w_state_nxt = ST_DRAIN;
            ST_DRAIN:  if (w_frame_start) w_state_nxt = ST_OFF;
            default:   w_state_nxt = ST_OFF;
        endcase
    end

    // NOTE: the frame buffer feeds SDATA directly, so it is reset like any control register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_OFF;
            r_pos     <= '0;
            r_started <= 1'b0;
            r_warm    <= '0;
            r_buf     <= '0;
            r_owner   <= 1'b0;
            r_lrclk   <= LEFT;
            r_sdata   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) r_owner <= w_win;

            if (!w_run) begin
                r_pos     <= '0;
                r_started <= 1'b0;
                r_warm    <= '0;
                r_buf     <= '0;
                r_lrclk   <= LEFT;
                r_sdata   <= 1'b0;
            end else if (w_fall) begin
                r_pos     <= w_pos_nxt;
                r_started <= 1'b1;
                r_lrclk   <= (w_pos_nxt >= PW'(SLOTBITS)) ? RIGHT : LEFT;
                if (w_frame_start) begin
                    r_buf   <= w_grant ? w_pair : '0;
                    r_sdata <= 1'b0;
                    if ((r_state == ST_WARMUP) && !w_warm_done) r_warm <= r_warm + WW'(1);
                end else if (is_data_bit(int'(w_pos_nxt), SLOTBITS, DATASIZE)) begin
                    // Left and right sit back to back, so one left shift walks both slots.
                    r_sdata <= r_buf[BW-1];
                    r_buf   <= {r_buf[BW-2:0], 1'b0};
                end else begin
                    r_sdata <= 1'b0;
                end
            end
        end
    end

    assign o_owner = r_owner;
    assign o_busy  = w_run;
    assign o_nshut = w_run;
    assign o_lrclk = r_lrclk;
    assign o_sdata = r_sdata;
endmodule

// File: tb/tb_amp3_i2s_scheduler.sv
// Self-checking bench for amp3_i2s_scheduler: a frame-level reference model predicts every output
// each clk cycle while directed steps and random source traffic exercise the scheduler.
module tb_amp3_i2s_scheduler;
    localparam int DATASIZE  = 12;
    localparam int SLOTBITS  = 16;
    localparam int CLKDIV    = 2;
    localparam int WARMUP    = 4;
    localparam int BCLK_CLK  = 2 * CLKDIV;
    localparam int FRAMEPOS  = 2 * SLOTBITS;
    localparam int FRAME_CLK = BCLK_CLK * FRAMEPOS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic o_owner, o_underrun, o_busy, o_bclk, o_lrclk, o_sdata, o_nshut;

    amp3_i2s_scheduler_if #(.DATASIZE(DATASIZE)) src0_if ();
    amp3_i2s_scheduler_if #(.DATASIZE(DATASIZE)) src1_if ();

    amp3_i2s_scheduler #(
        .DATASIZE(DATASIZE), .SLOTBITS(SLOTBITS), .CLKDIV(CLKDIV), .WARMUP_FRAMES(WARMUP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_enable   (enable),
        .i_src0     (src0_if),
        .i_src1     (src1_if),
        .o_owner    (o_owner),
        .o_underrun (o_underrun),
        .o_busy     (o_busy),
        .o_bclk     (o_bclk),
        .o_lrclk    (o_lrclk),
        .o_sdata    (o_sdata),
        .o_nshut    (o_nshut)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: time is counted in clk edges since the amp left OFF.
    bit                m_on, m_drain, m_owner;
    int                m_t;
    logic [DATASIZE-1:0] m_l, m_r;
    bit                e_fs, e_serve, e_r0, e_r1, e_under, last_fs;

    bit          reload0, reload1, rnd_arrive;
    logic [31:0] cap_sd, cap_lr;
    logic [1:0]  obs_grant;
    int          under_t[$];
    int          first_ready_t;
    int          ready_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_drain = 0; m_owner = 0; m_t = 0; m_l = '0; m_r = '0;
        e_fs = 0; e_serve = 0; e_r0 = 0; e_r1 = 0; e_under = 0; last_fs = 0;
    endtask

    // Expected combinational outputs for the cycle ending at edge m_t+1.
    task automatic model_comb();
        int  n, k, f;
        bit  win;
        n = m_t + 1;
        e_fs = 0; e_serve = 0; e_r0 = 0; e_r1 = 0; e_under = 0;
        if (m_on && (n % BCLK_CLK == 0)) begin
            k = n / BCLK_CLK;
            f = (k - 1) / FRAMEPOS;
            e_fs = ((k - 1) % FRAMEPOS) == 0;
            e_serve = e_fs && !m_drain && enable && (f >= WARMUP);
        end
        if (e_serve) begin
            if (src0_if.valid || src1_if.valid) begin
                if (m_owner == 1'b0) win = src0_if.valid ? 1'b0 : 1'b1;
                else                 win = src1_if.valid ? 1'b1 : 1'b0;
                e_r0 = !win;
                e_r1 = win;
            end else begin
                e_under = 1;
            end
        end
    endtask

    task automatic model_edge();
        last_fs = e_fs;
        if (!m_on) begin
            if (enable) begin m_on = 1; m_t = 0; m_drain = 0; end
        end else begin
            m_t++;
            if (e_fs && m_drain) begin
                m_on = 0;
            end else begin
                if (e_fs) begin
                    if (e_r0)      begin m_l = src0_if.data_l; m_r = src0_if.data_r; end
                    else if (e_r1) begin m_l = src1_if.data_l; m_r = src1_if.data_r; end
                    else           begin m_l = '0; m_r = '0; end
                    if (e_r0 || e_r1) m_owner = e_r1;
                end
                if (!enable) m_drain = 1;
            end
        end
    endtask

    task automatic check_outputs();
        logic eb, elr, esd;
        int   k, p;
        eb = 0; elr = 0; esd = 0;
        if (m_on) begin
            eb = 1'((m_t / CLKDIV) % 2);
            k = m_t / BCLK_CLK;
            if (k >= 1) begin
                p = (k - 1) % FRAMEPOS;
                elr = (p >= SLOTBITS);
                if (p >= 1 && p <= DATASIZE) esd = m_l[DATASIZE - p];
                else if (p >= SLOTBITS + 1 && p <= SLOTBITS + DATASIZE) esd = m_r[SLOTBITS + DATASIZE - p];
                if (m_t % BCLK_CLK == 0) begin
                    cap_sd[p] = o_sdata;
                    cap_lr[p] = o_lrclk;
                end
            end
        end
        check("busy",  o_busy,  m_on);
        check("nshut", o_nshut, m_on);
        check("bclk",  o_bclk,  eb);
        check("lrclk", o_lrclk, elr);
        check("sdata", o_sdata, esd);
        check("owner", o_owner, m_owner);
    endtask

    task automatic load0();
        src0_if.valid = 1; src0_if.data_l = DATASIZE'($urandom); src0_if.data_r = DATASIZE'($urandom);
    endtask

    task automatic load1();
        src1_if.valid = 1; src1_if.data_l = DATASIZE'($urandom); src1_if.data_r = DATASIZE'($urandom);
    endtask

    task automatic update_sources();
        if (e_r0) begin if (reload0) load0(); else src0_if.valid = 0; end
        if (e_r1) begin if (reload1) load1(); else src1_if.valid = 0; end
        if (rnd_arrive) begin
            if (!src0_if.valid && $urandom_range(0, 99) == 0) load0();
            if (!src1_if.valid && $urandom_range(0, 99) == 0) load1();
        end
    endtask

    task automatic step();
        @(negedge clk); #1;
        model_comb();
        check("src0_ready", src0_if.ready, e_r0);
        check("src1_ready", src1_if.ready, e_r1);
        check("underrun", o_underrun, e_under);
        if (e_fs) obs_grant = {src1_if.ready, src0_if.ready};
        if (o_underrun) under_t.push_back(m_t + 1);
        if (src1_if.ready && first_ready_t < 0) first_ready_t = m_t + 1;
        ready_seen += int'(src0_if.ready) + int'(src1_if.ready);
        @(posedge clk); #1;
        model_edge();
        check_outputs();
        update_sources();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_until_fs(input string tag);
        int i;
        i = 0;
        do begin step(); i++; end while (!last_fs && i < 4 * FRAME_CLK);
        if (!last_fs) begin
            n_checks++; n_errors++;
            $error("FAIL %s timeout observed=no_frame_start expected=frame_start", tag);
        end
    endtask

    task automatic run_until_p(input int target, input string tag);
        int i;
        bit hit;
        i = 0;
        hit = 0;
        while (!hit && i < 4 * FRAME_CLK) begin
            step(); i++;
            hit = m_on && (m_t > 0) && (m_t % BCLK_CLK == 0) && (((m_t / BCLK_CLK) - 1) % FRAMEPOS == target);
        end
        if (!hit) begin
            n_checks++; n_errors++;
            $error("FAIL %s timeout observed=no_position expected=p%0d", tag, target);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DATASIZE-1:0] wl, wr;
        logic [31:0]         rest;

        src0_if.valid = 0; src0_if.data_l = '0; src0_if.data_r = '0;
        src1_if.valid = 0; src1_if.data_l = '0; src1_if.data_r = '0;
        reload0 = 0; reload1 = 0; rnd_arrive = 0;
        first_ready_t = -1; ready_seen = 0; obs_grant = '0; cap_sd = '0; cap_lr = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {src0_if.ready, src1_if.ready, o_owner, o_underrun, o_busy,
                                o_bclk, o_lrclk, o_sdata, o_nshut}, 32'h0);
        rst = 0;
        run(3);

        // Power-up with no sources: four zero frames, then one underrun per frame
        under_t.delete();
        enable = 1;
        step();
        check("nshut_one_cycle", o_nshut, 1'b1);
        run(8 * FRAME_CLK - 1);
        check("underrun_count", under_t.size(), 4);
        if (under_t.size() == 4) begin
            check("first_underrun_t", under_t[0], WARMUP * FRAME_CLK + BCLK_CLK);
            for (int i = 1; i < 4; i++) check("underrun_period", under_t[i] - under_t[i-1], FRAME_CLK);
        end

        // One source with a fixed pair
        src0_if.valid = 1; src0_if.data_l = 12'hA5C; src0_if.data_r = 12'h3F1;
        cap_sd = '0; cap_lr = '0;
        run_until_fs("t2_fs");
        check("t2_grant", obs_grant, 2'b01);
        run(FRAME_CLK - BCLK_CLK);
        for (int i = 0; i < DATASIZE; i++) begin
            wl[DATASIZE-1-i] = cap_sd[1 + i];
            wr[DATASIZE-1-i] = cap_sd[SLOTBITS + 1 + i];
        end
        rest = cap_sd;
        for (int i = 1; i <= DATASIZE; i++) begin rest[i] = 1'b0; rest[SLOTBITS + i] = 1'b0; end
        check("t2_left_word", wl, 12'hA5C);
        check("t2_right_word", wr, 12'h3F1);
        check("t2_idle_bits", rest, 32'h0);
        check("lrclk_frame", cap_lr, 32'hFFFF_0000);

        // Sticky arbitration
        load0(); load1();
        reload0 = 0; reload1 = 1;
        run_until_fs("t3_fs1");
        check("t3_grant1", obs_grant, 2'b01);
        check("t3_owner1", o_owner, 1'b0);
        run_until_fs("t3_fs2");
        check("t3_grant2", obs_grant, 2'b10);
        check("t3_owner2", o_owner, 1'b1);
        load0();
        reload0 = 1; reload1 = 0;
        run_until_fs("t3_fs3");
        check("t3_grant3", obs_grant, 2'b10);
        check("t3_owner3", o_owner, 1'b1);
        run_until_fs("t3_fs4");
        check("t3_grant4", obs_grant, 2'b01);
        check("t3_owner4", o_owner, 1'b0);

        // Random traffic
        reload0 = 0; reload1 = 0; rnd_arrive = 1;
        run(12 * FRAME_CLK);
        rnd_arrive = 0;

        // Drain: enable low mid-frame, re-raised during drain
        load0(); reload0 = 1;
        run_until_p(5, "t4_p5");
        enable = 0;
        ready_seen = 0;
        run_until_p(10, "t4_p10");
        enable = 1;
        run_until_fs("t4_off");
        check("t4_ready_pulses", ready_seen, 0);
        check("t4_nshut_off", o_nshut, 1'b0);
        check("t4_bclk_off", o_bclk, 1'b0);
        check("t4_busy_off", o_busy, 1'b0);
        step();
        check("t4_busy_restart", o_busy, 1'b1);

        // Asynchronous reset mid-frame, then warm-up restarts
        reload0 = 0; src0_if.valid = 0;
        load1(); reload1 = 1;
        run(5 * FRAME_CLK);
        check("t5_owner_before", o_owner, 1'b1);
        run_until_p(20, "t5_p20");
        @(negedge clk); #2;
        rst = 1;
        #1;
        check("t5_reset_outputs", {src0_if.ready, src1_if.ready, o_owner, o_underrun, o_busy,
                                   o_bclk, o_lrclk, o_sdata, o_nshut}, 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst = 0;
        first_ready_t = -1;
        run(5 * FRAME_CLK);
        check("t5_first_grant_t", first_ready_t, WARMUP * FRAME_CLK + BCLK_CLK);
        check("t5_owner_after", o_owner, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
